// File: rtl/add_arb.sv
// add_arb -- round-robin arbiter/sequencer sharing one registered adder
// among NREQ requesters. One operation in flight at a time:
//   IDLE -> ISSUE (en pulse) -> WAIT (for ack) -> RESP -> IDLE
//
// Ports
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   req            per-requester request level
//   req_a, req_b   packed operands, requester i at [i*DW +: DW]
//   gnt            one-hot 1-cycle grant (operands captured)
//   rsp_valid      one-hot 1-cycle response strobe
//   rsp_data       result, held until the next response
//   rsp_err        timeout flag, qualified by rsp_valid
//   add_a, add_b   operands to the adder, held from issue to next grant
//   add_en         1-cycle enable to the adder
//   add_out        adder result
//   add_ack        adder acknowledge (only observed in WAIT)
//
// Optional feature: define ADD_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT
// cycles without add_ack (response with rsp_err=1, rsp_data=0).

module add_arb #(
    parameter int NREQ    = 4,
    parameter int DW      = 8,
    parameter int OW      = 16,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_a,
    input  logic [NREQ*DW-1:0]   req_b,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [OW-1:0]        rsp_data,
    output logic                 rsp_err,
    output logic [DW-1:0]        add_a,
    output logic [DW-1:0]        add_b,
    output logic                 add_en,
    input  logic [OW-1:0]        add_out,
    input  logic                 add_ack
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                   state;
    logic [PW-1:0]            ptr;
    logic [PW-1:0]            owner;

    // Operand buses viewed per requester.
    logic [NREQ-1:0][DW-1:0]  opa, opb;
    assign opa = req_a;
    assign opb = req_b;

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
        onehot = {{(NREQ-1){1'b0}}, 1'b1} << i;
    endfunction

    // Round-robin pick: first set req bit scanning upward from ptr, wrapping.
    logic          found;
    logic [PW-1:0] win;
    int            idx;
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[idx[PW-1:0]]) begin
                found = 1'b1;
                win   = idx[PW-1:0];
            end
        end
    end

    logic [PW-1:0] ptr_nxt;
    assign ptr_nxt = (owner == PW'(NREQ-1)) ? '0 : owner + 1'b1;

`ifdef ADD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT+1);
    logic [CW-1:0] cnt;
    logic          err_q;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            add_a     <= '0;
            add_b     <= '0;
            add_en    <= 1'b0;
`ifdef ADD_ARB_TIMEOUT_EN
            cnt       <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        add_a  <= opa[win];
                        add_b  <= opb[win];
                        add_en <= 1'b1;
                        gnt    <= onehot(win);
                        owner  <= win;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    add_en <= 1'b0;
                    gnt    <= '0;
`ifdef ADD_ARB_TIMEOUT_EN
                    cnt    <= '0;
`endif
                    state  <= WAIT;
                end
                WAIT: begin
                    if (add_ack) begin
                        rsp_data  <= add_out;
                        rsp_valid <= onehot(owner);
                        ptr       <= ptr_nxt;
                        state     <= RESP;
`ifdef ADD_ARB_TIMEOUT_EN
                        err_q     <= 1'b0;
                    end else if (cnt == CW'(TIMEOUT-1)) begin
                        // This is the TIMEOUT-th WAIT cycle without ack.
                        rsp_data  <= '0;
                        rsp_valid <= onehot(owner);
                        err_q     <= 1'b1;
                        ptr       <= ptr_nxt;
                        state     <= RESP;
                    end else begin
                        cnt       <= cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    rsp_valid <= '0;
`ifdef ADD_ARB_TIMEOUT_EN
                    err_q     <= 1'b0;
`endif
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_arb.sv
// Testbench for add_arb: directed steps plus randomized operations, with a
// round-robin reference model (integer pointer + modulo scan) and a
// registered-adder model on the adder port.

module tb_add_arb;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int OW = 16;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req;
    logic [N*DW-1:0]   req_a, req_b;
    logic [N-1:0]      gnt, rsp_valid;
    logic [OW-1:0]     rsp_data;
    logic              rsp_err;
    logic [DW-1:0]     add_a, add_b;
    logic              add_en;
    logic [OW-1:0]     add_out;
    logic              add_ack;

    logic              ack_r, ack_force, ack_kill;

    int tests = 0;
    int fails = 0;
    int m_ptr = 0;
    logic [DW-1:0] av [N];
    logic [DW-1:0] bv [N];

    add_arb #(.NREQ(N), .DW(DW), .OW(OW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .add_a(add_a), .add_b(add_b), .add_en(add_en),
        .add_out(add_out), .add_ack(add_ack)
    );

    always #5 clk = ~clk;

    // Registered adder: result and ack one cycle after en.
    always @(posedge clk) begin
        ack_r <= add_en & ~ack_kill;
        if (add_en) add_out <= OW'(add_a) + OW'(add_b);
    end
    assign add_ack = ack_r | ack_force;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            req_a[i*DW +: DW] = av[i];
            req_b[i*DW +: DW] = bv[i];
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_ptr = 0;
        tick();
    endtask

    // One full operation starting from IDLE; drop releases the winner's req.
    task automatic op(input logic [N-1:0] r, input bit drop);
        int w;
        int sum;
        w = pick(r, m_ptr);
        sum = int'(av[w]) + int'(bv[w]);
        req = r;
        pack();
        tick();
        chk("gnt", gnt, 32'(1) << w);
        chk("add_en_hi", add_en, 1);
        chk("add_a", add_a, av[w]);
        chk("add_b", add_b, bv[w]);
        if (drop) req[w] = 1'b0;
        tick();
        chk("gnt_clr", gnt, 0);
        chk("add_en_lo", add_en, 0);
        chk("rsp_early", rsp_valid, 0);
        tick();
        chk("rsp_valid", rsp_valid, 32'(1) << w);
        chk("rsp_data", rsp_data, sum);
        chk("rsp_err", rsp_err, 0);
        m_ptr = (w + 1) % N;
        tick();
        chk("rsp_clr", rsp_valid, 0);
        chk("rsp_hold", rsp_data, sum);
    endtask

    initial begin
        int w, n, seen;
        bit got;
        reset = 1'b1; req = '0; req_a = '0; req_b = '0;
        ack_force = 1'b0; ack_kill = 1'b0;
        for (int i = 0; i < N; i++) begin av[i] = '0; bv[i] = '0; end
        tick(); tick();

        // Reset state
        chk("rst_gnt", gnt, 0);
        chk("rst_rspv", rsp_valid, 0);
        chk("rst_rspd", rsp_data, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_a", add_a, 0);
        chk("rst_b", add_b, 0);
        chk("rst_en", add_en, 0);
        reset = 1'b0;
        tick();

        // Single request
        av[0] = 8'd7; bv[0] = 8'd1;
        op(4'b0001, 1'b1);
        req = '0;
        do_reset();

        // All requesters held
        av[0] = 8'd6;  bv[0] = 8'd8;
        av[1] = 8'd7;  bv[1] = 8'd0;
        av[2] = 8'd71; bv[2] = 8'd23;
        av[3] = 8'd14; bv[3] = 8'd11;
        for (int k = 0; k < 5; k++) op(4'b1111, 1'b0);

        // Wrap: serve 3, then 1001 must go to 0
        op(4'b1000, 1'b1);
        op(4'b1001, 1'b1);
        req = '0;

        // Maximum sum
        av[2] = 8'hFF; bv[2] = 8'hFF;
        op(4'b0100, 1'b1);
        req = '0;

        // Spurious ack in IDLE
        ack_force = 1'b1;
        tick();
        ack_force = 1'b0;
        chk("spur_rsp0", rsp_valid, 0);
        tick();
        chk("spur_rsp1", rsp_valid, 0);
        op(4'b0010, 1'b1);     // still IDLE: grant comes right away
        req = '0;

        // Reset in WAIT (ptr is non-zero beforehand)
        av[2] = 8'd33; bv[2] = 8'd44; pack();
        req = 4'b0100;
        tick();
        chk("rw_gnt", gnt, 4'b0100);
        req = '0;
        tick();
        reset = 1'b1;
        #1;
        chk("rw_gnt0", gnt, 0);
        chk("rw_rspv0", rsp_valid, 0);
        chk("rw_rspd0", rsp_data, 0);
        chk("rw_a0", add_a, 0);
        chk("rw_b0", add_b, 0);
        chk("rw_en0", add_en, 0);
        tick();
        reset = 1'b0;
        m_ptr = 0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (rsp_valid != 0) seen++;
        end
        chk("rw_norsp", seen, 0);
        op(4'b1111, 1'b1);     // must be granted from ptr 0
        req = '0;

        // Randomized operations
        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < N; i++) begin
                av[i] = DW'($urandom);
                bv[i] = DW'($urandom);
            end
            op(N'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
        end
        req = '0;
        tick();

        // Adder never acknowledges
        ack_kill = 1'b1;
        av[1] = 8'd5; bv[1] = 8'd9; pack();
        w = pick(4'b0010, m_ptr);
        req = 4'b0010;
        tick();
        chk("to_gnt", gnt, 32'(1) << w);
        req = '0;
`ifdef ADD_ARB_TIMEOUT_EN
        n = 0; got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            tick();
            n++;
            if (rsp_valid != 0) got = 1'b1;
        end
        chk("to_seen", got, 1);
        chk("to_lat", n, TO + 1);
        chk("to_rspv", rsp_valid, 32'(1) << w);
        chk("to_err", rsp_err, 1);
        chk("to_data", rsp_data, 0);
        m_ptr = (w + 1) % N;
        ack_kill = 1'b0;
        ack_force = 1'b1;      // late ack
        tick();
        ack_force = 1'b0;
        chk("to_clr", rsp_valid, 0);
        tick();
        chk("to_late", rsp_valid, 0);
        op(4'b0001, 1'b1);
        req = '0;
`else
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (rsp_valid != 0) seen++;
        end
        chk("to_none", seen, 0);
        ack_kill = 1'b0;
        do_reset();
        op(4'b0100, 1'b1);
        req = '0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/add_arb.md
# add_arb

Round-robin arbiter and sequencer that shares one registered 8-bit adder (`en`/`ack` handshake, `out` = `a` + `b`) among `NREQ` requesters. It sits between the requesters and the adder's RTL port. The block accepts one request at a time, issues a single-cycle `en` pulse, waits for `ack`, and returns the sum to the owning requester. Only one operation is in flight at any time.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `DW`, default 8: operand width; must match the adder `a`/`b` width.
- `OW`, default 16: result width; must match the adder `out` width.
- `TIMEOUT`, default 16: WAIT-state cycle limit. Used only when `ADD_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  NREQ  request per requester.
- `req_a`  in  NREQ*DW  operand a; requester i uses bits [i*DW +: DW].
- `req_b`  in  NREQ*DW  operand b, same packing as `req_a`.
- `gnt`  out  NREQ  one-hot, 1-cycle pulse; operands are captured.
- `rsp_valid`  out  NREQ  one-hot, 1-cycle pulse; result available.
- `rsp_data`  out  OW  result, valid while any `rsp_valid` bit is high.
- `rsp_err`  out  1  timeout flag, qualified by `rsp_valid`.
- `add_a`, `add_b`  out  DW  operands to the adder.
- `add_en`  out  1  enable to the adder.
- `add_out`  in  OW  adder result.
- `add_ack`  in  1  adder acknowledge.

## Operation
- Reset values: FSM in IDLE, round-robin pointer `ptr` = 0, and every output (`gnt`, `rsp_valid`, `rsp_data`, `rsp_err`, `add_a`, `add_b`, `add_en`) = 0. All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, when `req` != 0:
  - Select the first set bit scanning from `ptr` upward, wrapping modulo NREQ.
  - Register the winner's operands onto `add_a`/`add_b`.
  - Set `add_en` = 1 and `gnt[i]` = 1, record owner = i, go to ISSUE.
- ISSUE: clear `add_en` and `gnt`, go to WAIT.
- WAIT, when `add_ack` = 1:
  - `rsp_data` <= `add_out`, `rsp_valid[owner]` <= 1, `ptr` <= (owner+1) mod NREQ.
  - Go to RESP.
- RESP: clear `rsp_valid`, go to IDLE. `rsp_data` holds its value until the next response.
- `add_a`/`add_b` hold their values from issue until the next grant.
- `add_ack` is ignored in IDLE, ISSUE and RESP.
- Requester rule:
  - Hold `req` and the operands stable until `gnt[i]` is seen.
  - Drop `req` on the cycle after `gnt[i]`.
  - `req` still high at the next arbitration counts as a new request.
- Arithmetic: no truncation or extension; `rsp_data` = `add_out` bit-for-bit. The maximum sum is 510, which fits in 16 bits.
- Requests arriving while not in IDLE wait; nothing is queued beyond the `req` level.

## Timing
- E0: IDLE samples `req`. After E0: `gnt` and `add_en` are high.
- E1: the adder samples `en`. After E1: `add_ack` is high and `add_en` is low.
- E2: WAIT sees `add_ack`. After E2: `rsp_valid` is high.
- E3: after E3 the FSM is back in IDLE. The earliest next grant is after E4.
- Latency: request to response = 3 cycles. Throughput: 1 operation per 4 cycles.
- Simultaneous requests: exactly one grant. The others are served in round-robin order, with no starvation.
- Wrap: `ptr` = NREQ-1, then owner NREQ-1 is served, then `ptr` = 0.
- Reset mid-operation (any state): immediate return to reset values. The in-flight result is discarded and no `rsp_valid` is issued.

## Configuration
- `ADD_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and counts each WAIT cycle without `add_ack`.
  - When the count reaches `TIMEOUT`, assert `rsp_valid[owner]`, `rsp_err` = 1 and `rsp_data` = 0, advance `ptr`, and go to RESP.
  - A late `add_ack` arriving after the timeout is ignored.
- `ADD_ARB_TIMEOUT_EN` undefined: no counter; WAIT waits indefinitely; `rsp_err` is tied to 0.

## Test plan
- Single request: `req` = 0001, a=7, b=1. Require `gnt` = 0001 one cycle after sampling, then `rsp_valid` = 0001 with `rsp_data` = 8, three cycles after the request.
- All requesters at once: `req` = 1111 held, operands (6,8), (7,0), (71,23), (14,11). Require grants in order 0, 1, 2, 3, 0 and results 14, 7, 94, 25, each `rsp_valid` on the correct bit.
- Round-robin wrap: serve requester 3, then raise `req` = 1001. Require a grant to requester 0 first.
- Reset in WAIT: assert `reset` one cycle after `gnt`. Require every output 0 immediately, no `rsp_valid`, and the next request granted from `ptr` 0.
- Spurious `add_ack` in IDLE with `req` = 0: require no `rsp_valid` and the FSM staying in IDLE.
- With `ADD_ARB_TIMEOUT_EN` defined and `add_ack` forced to 0, TIMEOUT=16: require `rsp_valid` with `rsp_err` = 1 and `rsp_data` = 0 after 16 WAIT cycles. Without the macro, require no response after 100 cycles.
